ram_responder: RTL and testbench

- Memory-side responder for the word-wide RAM request interface driven by the data cache (ce/we/sel/addr/data out, data + data_ready back).
- Each accepted 32-bit request is served as four byte-serial accesses on a byte-wide synchronous memory port.
- Reads are pipelined against a fixed memory read latency. The block returns a single-cycle data_ready pulse per request.
- Sits between the cache and the on-chip/external byte RAM.

---
 rtl/ram_responder_pkg.sv | 29 ++
 rtl/ram_responder_rd_lat_pipe.sv | 46 ++++
 rtl/ram_responder.sv | 192 +++++++++++++++++++
 tb/tb_ram_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: definitions shared by the byte-serial RAM responder.
//   - state_e      : controller state encoding
//   - NUM_LANES    : bytes per request word
//   - LAST_LANE    : index of the final byte lane
//   - RD_LAT_MIN/MAX : legal memory read latency bounds
//   - RST_ACTIVE   : level of rst/rst_ni that holds the block in reset
//   - lane_byte()  : extracts one little-endian byte lane from a word
package ram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int unsigned NUM_LANES  = 4;
  localparam logic [1:0]  LAST_LANE  = 2'd3;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam logic        RST_ACTIVE = 1'b0;

  // Byte k of a 32-bit word sits at bits [8k+7:8k].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ram_responder_rd_lat_pipe.sv
// ram_responder_rd_lat_pipe: DEPTH-stage delay line for read issue tags.
// A {valid, lane} tag enters in the cycle its address is on the memory port
// and leaves DEPTH cycles later, exactly when the matching byte is on mem_din.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears every stage
//   vld_i   : a read byte was issued this cycle
//   lane_i  : lane index of that read
//   vld_o   : capture enable for the byte currently on mem_din
//   lane_o  : lane the captured byte belongs to
module ram_responder_rd_lat_pipe
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vld_i,
  input  logic [1:0] lane_i,
  output logic       vld_o,
  output logic [1:0] lane_o
);

  logic       vld_q  [DEPTH];
  logic [1:0] lane_q [DEPTH];

  // Shift register: stage 0 takes the new tag, later stages take their predecessor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RST_ACTIVE) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        lane_q[i] <= 2'b00;
      end
    end else begin
      vld_q[0]  <= vld_i;
      lane_q[0] <= lane_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        lane_q[i] <= lane_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign lane_o = lane_q[DEPTH-1];

endmodule

// File: rtl/ram_responder.sv
// ram_responder: serves 32-bit cache RAM requests as four byte accesses on a
// byte-wide synchronous memory, lanes 0..3 in ascending order.
//   clk            : clock
//   rst            : asynchronous active-low reset
//   ram_ce_i       : request valid (level)
//   ram_we_i       : 1 = write, 0 = read
//   ram_addr_i     : byte address (bits [1:0] and above ADDR_W-1 ignored)
//   ram_sel_i      : write byte enables
//   ram_data_i     : write word
//   ram_data_o     : last completed read word (registered)
//   ram_data_ready : one-cycle completion pulse
//   mem_a_o        : memory byte address
//   mem_dout_o     : write byte
//   mem_din_i      : read byte, valid RD_LAT cycles after its address
//   mem_rd_o       : read strobe
//   mem_wr_o       : write strobe
// All memory-side outputs are registered, so the accept edge already loads
// lane 0 and the strobes appear in the first cycle after acceptance.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              ram_data_ready,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  output logic              mem_rd_o,
  output logic              mem_wr_o
);

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-3:0]   word_q, word_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;

  logic                cap_vld_s;
  logic [1:0]          cap_lane_s;
  logic [1:0]          lane_nxt_s;
  logic                unused_addr_s;

  assign lane_nxt_s    = lane_q + 2'd1;
  assign unused_addr_s = ^{ram_addr_i[31:ADDR_W], ram_addr_i[1:0]};

  // The tag enters with the registered strobe, i.e. in the cycle the address is on the port.
  ram_responder_rd_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_lat_pipe (
    .clk_i  (clk),
    .rst_ni (rst),
    .vld_i  (mem_rd_q),
    .lane_i (mem_a_q[1:0]),
    .vld_o  (cap_vld_s),
    .lane_o (cap_lane_s)
  );

  // Next-state, request latch, byte assembly and next memory-port values.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    word_d     = word_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;

    if (cap_vld_s) begin
      asm_d[{cap_lane_s, 3'b000} +: 8] = mem_din_i;
    end else begin
      asm_d = asm_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ram_ce_i) begin
          word_d  = ram_addr_i[ADDR_W-1:2];
          sel_d   = ram_sel_i;
          wdata_d = ram_data_i;
          lane_d  = 2'd0;
          mem_a_d = {ram_addr_i[ADDR_W-1:2], 2'b00};
          if (ram_we_i) begin
            state_d    = ST_WR;
            mem_wr_d   = ram_sel_i[0];
            mem_dout_d = lane_byte(ram_data_i, 2'd0);
          end else begin
            state_d  = ST_RD_ISSUE;
            mem_rd_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (lane_q != LAST_LANE) begin
          lane_d     = lane_nxt_s;
          mem_a_d    = {word_q, lane_nxt_s};
          mem_wr_d   = sel_q[lane_nxt_s];
          mem_dout_d = lane_byte(wdata_q, lane_nxt_s);
        end else begin
          state_d = ST_DONE;
          ready_d = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        if (lane_q != LAST_LANE) begin
          lane_d   = lane_nxt_s;
          mem_a_d  = {word_q, lane_nxt_s};
          mem_rd_d = 1'b1;
        end else begin
          state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        // Lane 3 lands this cycle; fold it straight into the output word.
        if (cap_vld_s && (cap_lane_s == LAST_LANE)) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          rdata_d = {mem_din_i, asm_q[23:0]};
        end else begin
          state_d = ST_RD_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q    <= ST_IDLE;
      lane_q     <= 2'd0;
      word_q     <= '0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign ram_data_o     = rdata_q;
  assign ram_data_ready = ready_q;
  assign mem_a_o        = mem_a_q;
  assign mem_dout_o     = mem_dout_q;
  assign mem_rd_o       = mem_rd_q;
  assign mem_wr_o       = mem_wr_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: two responders (RD_LAT=1 and RD_LAT=3), each attached to
// its own behavioural byte RAM. Requests are checked against a word-level
// reference memory: ready cycle, pulse count, strobe cycles and read data.
module tb_ram_responder;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  ce;
  logic [1:0]  we;
  logic [31:0] addr   [2];
  logic [3:0]  sel    [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic [1:0]  ready;
  logic [16:0] mem_a  [2];
  logic [7:0]  mem_dout [2];
  logic [7:0]  mem_din  [2];
  logic [1:0]  mem_rd;
  logic [1:0]  mem_wr;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt   [2] = '{0, 0};
  int both_cnt    [2] = '{0, 0};
  int exp_pulses  [2] = '{0, 0};
  logic [31:0] last_rd [2];
  logic [7:0]  ref_mem [2][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0]  env_ram [0:(1<<17)-1];
    logic [16:0] rp_a [LAT];
    logic        rp_v [LAT];

    ram_responder #(
      .ADDR_W (17),
      .RD_LAT (LAT)
    ) u_dut (
      .clk            (clk),
      .rst            (rst_n[g]),
      .ram_ce_i       (ce[g]),
      .ram_we_i       (we[g]),
      .ram_addr_i     (addr[g]),
      .ram_sel_i      (sel[g]),
      .ram_data_i     (wdata[g]),
      .ram_data_o     (rdata[g]),
      .ram_data_ready (ready[g]),
      .mem_a_o        (mem_a[g]),
      .mem_dout_o     (mem_dout[g]),
      .mem_din_i      (mem_din[g]),
      .mem_rd_o       (mem_rd[g]),
      .mem_wr_o       (mem_wr[g])
    );

    // Byte RAM: writes land on the edge, reads return LAT cycles after the address.
    always @(posedge clk) begin
      if (mem_wr[g]) env_ram[mem_a[g]] <= mem_dout[g];
      rp_a[0] <= mem_a[g];
      rp_v[0] <= mem_rd[g];
      for (int i = 1; i < LAT; i++) begin
        rp_a[i] <= rp_a[i-1];
        rp_v[i] <= rp_v[i-1];
      end
    end

    assign mem_din[g] = rp_v[LAT-1] ? env_ram[rp_a[LAT-1]] : 8'hEE;
  end

  // Protocol monitor: completion pulses and strobe exclusivity.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d]) pulse_cnt[d] <= pulse_cnt[d] + 1;
      if (mem_rd[d] && mem_wr[d]) both_cnt[d] <= both_cnt[d] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One request on responder d. Entered just after a clock edge with the
  // responder idle; the next edge is the accept edge (cycle 0). drop_cyc > 0
  // releases ce in that cycle; chain returns in the cycle after ready with
  // ce still high so the caller can switch to the next request.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] dt,
                        input int drop_cyc, input bit chain);
    int          base;
    int          exp_rdy;
    int          rdy_cyc;
    int          rdy_n;
    logic [31:0] rd_mask;
    logic [31:0] wr_mask;
    logic [31:0] got;
    logic [31:0] exp_word;
    base     = int'(a[9:2]) * 4;
    exp_rdy  = w ? 5 : 5 + lat_of(d);
    exp_word = {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = dt;
    @(posedge clk); #1;
    rdy_cyc = 0; rdy_n = 0; rd_mask = 32'd0; wr_mask = 32'd0; got = 32'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == drop_cyc) ce[d] = 1'b0;
      @(negedge clk);
      if (mem_rd[d]) rd_mask[cyc] = 1'b1;
      if (mem_wr[d]) wr_mask[cyc] = 1'b1;
      if (ready[d]) begin
        rdy_n++;
        if (rdy_cyc == 0) begin
          rdy_cyc = cyc;
          got     = rdata[d];
        end
      end
      @(posedge clk); #1;
      if (rdy_cyc != 0 && chain) break;
      if (rdy_cyc != 0 && cyc == rdy_cyc) ce[d] = 1'b0;
      if (rdy_cyc != 0 && cyc >= rdy_cyc + 2) break;
    end
    exp_pulses[d]++;
    check_eq(w ? "wr_ready_cycle" : "rd_ready_cycle", 64'(rdy_cyc), 64'(exp_rdy));
    check_eq("ready_pulses", 64'(rdy_n), 64'd1);
    check_eq("rd_strobe_cycles", 64'(rd_mask), w ? 64'd0 : 64'h1E);
    check_eq("wr_strobe_cycles", 64'(wr_mask), w ? 64'({s, 1'b0}) : 64'd0);
    if (w) begin
      check_eq("wr_keeps_rdata", 64'(got), 64'(last_rd[d]));
      for (int k = 0; k < 4; k++) begin
        if (s[k]) ref_mem[d][base+k] = dt[8*k +: 8];
      end
    end else begin
      check_eq("rd_data", 64'(got), 64'(exp_word));
      last_rd[d] = exp_word;
    end
  endtask

  // Write request on d, reset pulled low in cycle 3 (after lanes 0 and 1 landed).
  task automatic reset_mid_write(input int d);
    ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h300; sel[d] = 4'hF; wdata[d] = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ce[d] = 1'b0;
    @(posedge clk); #1;
    rst_n[d] = 1'b0;
    #1;
    check_eq("rst_mid_outputs",
             {4'd0, ready[d], mem_rd[d], mem_wr[d], mem_a[d], mem_dout[d], rdata[d]}, 64'd0);
    ref_mem[d][12'h300] = 8'h44;
    ref_mem[d][12'h301] = 8'h33;
    last_rd[d] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  word;
    logic        w;
    int          drop;
    bit          chain;
    rst_n = 2'b00; ce = 2'b00; we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'd0; sel[d] = 4'd0; wdata[d] = 32'd0; last_rd[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_outputs",
               {4'd0, ready[d], mem_rd[d], mem_wr[d], mem_a[d], mem_dout[d], rdata[d]}, 64'd0);
    end
    rst_n = 2'b11;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      // Fill the whole test region so every later read has a known value.
      for (int i = 0; i < 256; i++) begin
        r = $urandom();
        do_req(d, 1'b1, i * 4, 4'hF, r, 0, 1'b0);
      end
      // Known bytes 11,22,33,44 at 0x100..0x103, then read them back.
      do_req(d, 1'b1, 32'h100, 4'hF, 32'h44332211, 0, 1'b0);
      do_req(d, 1'b0, 32'h100, 4'h0, 32'd0, 0, 1'b0);
      // Partial write: only lanes 0 and 2.
      do_req(d, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, 0, 1'b0);
      do_req(d, 1'b0, 32'h200, 4'h0, 32'd0, 0, 1'b0);
      // No enables: four cycles, no strobes.
      do_req(d, 1'b1, 32'h108, 4'b0000, 32'h12345678, 0, 1'b0);
      // Back-to-back read then write with ce held across the switch.
      do_req(d, 1'b0, 32'h100, 4'h0, 32'd0, 0, 1'b1);
      do_req(d, 1'b1, 32'h104, 4'hF, 32'hCAFEF00D, 0, 1'b0);
      // ce released in cycle 2 of a read.
      do_req(d, 1'b0, 32'h100, 4'h0, 32'd0, 2, 1'b0);
      // Randomised traffic, ignored address bits scrambled.
      for (int i = 0; i < 40; i++) begin
        r     = $urandom();
        word  = 8'($urandom_range(0, 255));
        w     = 1'($urandom_range(0, 1));
        drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        chain = (i != 39) && ($urandom_range(0, 3) == 0);
        do_req(d, w, {r[31:17], 7'd0, word, r[1:0]}, 4'($urandom_range(0, 15)),
               $urandom(), drop, chain);
      end
      reset_mid_write(d);
      do_req(d, 1'b0, 32'h300, 4'h0, 32'd0, 0, 1'b0);
      // Final sweep: every word of the region must match the reference.
      for (int i = 0; i < 256; i++) begin
        do_req(d, 1'b0, i * 4, 4'h0, 32'd0, 0, 1'b0);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("total_ready_pulses", 64'(pulse_cnt[d]), 64'(exp_pulses[d]));
      check_eq("rd_wr_overlap", 64'(both_cnt[d]), 64'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
